baccarat_card_datapath: RTL and testbench
=========================================

# baccarat_card_datapath

Card-holding datapath for the baccarat game. It generates the next card to deal and latches it into one of six hand registers (player cards 1–3, dealer cards 1–3) when the round state machine pulses the matching load strobe. It continuously presents the baccarat scores `pscore`/`dscore` and the player's third card `pcard3`, which the state machine consumes to choose third-card draws and the winner. It sits directly upstream of the round state machine and shares its clock.

## Interface
Parameters:
- `CARD_W`, 4: card code width. Code 0 means empty, 1 = Ace, 2–10 are pips, 11–13 are J/Q/K.

Ports:
- `slow_clock`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  **synchronous, active-high**.
- `load_pcard1`, `load_pcard2`, `load_pcard3`  in  1 each  latch the current deal card into the player slot.
- `load_dcard1`, `load_dcard2`, `load_dcard3`  in  1 each  latch the current deal card into the dealer slot.
- `pcard1`..`pcard3`, `dcard1`..`dcard3`  out  CARD_W each  registered hand contents.
- `pscore`, `dscore`  out  4 each  hand score, range 0–9.
- `deal_card`  out  CARD_W  card that a load in this cycle will capture.
- `cards_dealt`  out  3  number of successful slot loads since reset, range 0–6.
- `load_error`  out  1  sticky flag for a protocol violation.

## Operation
- **Deal source.** `deal_card` is a counter that advances every cycle, 1→2→…→13→1. It never takes the value 0.
- **Slot load.** When a strobe is high at an edge, its slot takes `deal_card` and the counter advances as usual.
- **Card value.** A card's value is its code for codes 1–9. Codes 0 and 10–13 have value 0.
- **Scores.**
  - `pscore` = (value(pcard1) + value(pcard2) + value(pcard3)) mod 10.
  - `dscore` is computed the same way from the dealer slots.
  - Use a 5-bit intermediate sum (max 27), then reduce by conditional subtraction of 20 or 10. No divider.
  - Scores are combinational from the slot registers.
- **Slot already loaded.** If a strobe targets a slot that is already nonzero, the slot is overwritten, `load_error` is set, and `cards_dealt` does not increment.
- **Simultaneous strobes.** If more than one strobe is high in the same cycle:
  - every selected slot takes the same `deal_card`;
  - `load_error` is set;
  - `cards_dealt` increments by the number of previously empty slots loaded, saturating at 6.
- **Error clear.** `load_error` stays set until `reset`.
- **No load.** With no strobe high, the slots hold their values.

## Timing
- **Reset values** (at the first edge with `reset`=1):
  - all six slots = 0;
  - `pscore` = `dscore` = 0;
  - `deal_card` = 1;
  - `cards_dealt` = 0;
  - `load_error` = 0.
- **Reset priority.** `reset` overrides all strobes in the same cycle, including mid-hand.
- **Load latency.** A strobe sampled at edge N makes the slot value visible after edge N. `pscore`/`dscore` reflect it in that same cycle (combinational, zero added latency).
- **Consumer timing.** Back-to-back strobes in consecutive cycles are legal. The state machine samples scores one cycle after the last load strobe.
- **Card sequence from reset.** The first cycle after reset releases has `deal_card`=1. The card value at cycle k after reset is ((k mod 13)+1).

## Structure
- **Shared package `baccarat_pkg`:**
  - `CARD_W`;
  - card code constants: `CARD_EMPTY`=0, `CARD_ACE`=1, `CARD_TEN`=10, `CARD_KING`=13;
  - `SCORE_W`=4;
  - a `card_value` function.
- **Sub-module `card_reg`:** CARD_W-bit register with synchronous reset and load enable, instantiated six times.
- **Top-level logic:** counter, `cards_dealt`, error flag, and both score reducers.

## Test plan
- **Basic deal order.** Release reset, then strobe p1, d1, p2, d2 on consecutive cycles 0–3. Expect:
  - pcard1=1, dcard1=2, pcard2=3, dcard2=4;
  - pscore=4, dscore=6;
  - `cards_dealt`=4, `load_error`=0.
- **Face cards and mod 10.** Strobe pcard1 at cycle 8 and pcard2 at cycle 9 (cards 9 and 10), then pcard3 at cycle 12 (card 13). Expect pscore=9. Next, load pcard3 fresh after reset at cycle 7 (card 8) with 9 and 10 held. Expect pscore=7.
- **Counter wrap.** Hold reset low for 13 cycles without strobes. Expect `deal_card` goes 13→1 and the slots stay 0.
- **Simultaneous strobes.** Raise load_pcard1 and load_dcard1 together at cycle 2. Expect:
  - both slots = 3;
  - `cards_dealt`=2;
  - `load_error`=1, which stays set until reset.
- **Overwrite.** Strobe load_pcard1 at cycles 0 and 5. Expect:
  - pcard1=6;
  - `cards_dealt`=1;
  - `load_error`=1.
- **Reset mid-hand.** Assert reset during a strobe after three cards are dealt. Next cycle expect:
  - all slots 0, scores 0;
  - `deal_card`=1;
  - `cards_dealt`=0, `load_error`=0.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared card constants and helpers for the baccarat datapath.
package baccarat_pkg;

  localparam int CARD_W  = 4;
  localparam int SCORE_W = 4;

  localparam logic [CARD_W-1:0] CARD_EMPTY = 4'd0;
  localparam logic [CARD_W-1:0] CARD_ACE   = 4'd1;
  localparam logic [CARD_W-1:0] CARD_TEN   = 4'd10;
  localparam logic [CARD_W-1:0] CARD_KING  = 4'd13;

  // Tens, faces and the empty code all count as zero.
  function automatic logic [SCORE_W-1:0] card_value(
    input logic [CARD_W-1:0] c
  );
    if (c != CARD_EMPTY && c < CARD_TEN)
      card_value = c[SCORE_W-1:0];
    else
      card_value = '0;
  endfunction

endpackage

// File: rtl/baccarat_card_datapath_card_reg.sv
// One hand slot: card register with sync reset and load enable.
module card_reg #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] card_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      card_q <= '0;
    else if (en_i)
      card_q <= d_i;
  end

  assign q_o = card_q;

endmodule

// File: rtl/baccarat_card_datapath.sv
// Deal counter, six hand slots, load bookkeeping and hand scores.
module baccarat_card_datapath #(
  parameter int CARD_W = baccarat_pkg::CARD_W
) (
  input  logic              slow_clock,
  input  logic              reset,
  input  logic              load_pcard1,
  input  logic              load_pcard2,
  input  logic              load_pcard3,
  input  logic              load_dcard1,
  input  logic              load_dcard2,
  input  logic              load_dcard3,
  output logic [CARD_W-1:0] pcard1,
  output logic [CARD_W-1:0] pcard2,
  output logic [CARD_W-1:0] pcard3,
  output logic [CARD_W-1:0] dcard1,
  output logic [CARD_W-1:0] dcard2,
  output logic [CARD_W-1:0] dcard3,
  output logic [3:0]        pscore,
  output logic [3:0]        dscore,
  output logic [CARD_W-1:0] deal_card,
  output logic [2:0]        cards_dealt,
  output logic              load_error
);

  import baccarat_pkg::CARD_EMPTY;
  import baccarat_pkg::CARD_ACE;
  import baccarat_pkg::CARD_KING;
  import baccarat_pkg::SCORE_W;
  import baccarat_pkg::card_value;

  logic [CARD_W-1:0] deal_q, deal_d;
  logic [2:0]        dealt_q, dealt_d;
  logic              err_q, err_d;
  logic [5:0]        ld;
  logic [CARD_W-1:0] slot [6];
  logic [2:0]        n_ld, n_new;
  logic              hit_full;
  logic [3:0]        dealt_sum;

  // Slot order: p1 p2 p3 d1 d2 d3.
  assign ld = {load_dcard3, load_dcard2, load_dcard1,
               load_pcard3, load_pcard2, load_pcard1};

  for (genvar i = 0; i < 6; i++) begin : g_slot
    card_reg #(.W(CARD_W)) u_slot (
      .clk_i (slow_clock),
      .rst_i (reset),
      .en_i  (ld[i]),
      .d_i   (deal_q),
      .q_o   (slot[i])
    );
  end

  always_comb begin
    n_ld     = '0;
    n_new    = '0;
    hit_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ld[i]) begin
        n_ld = n_ld + 3'd1;
        if (slot[i] == CARD_EMPTY)
          n_new = n_new + 3'd1;
        else
          hit_full = 1'b1;
      end
    end
    deal_d = (deal_q == CARD_KING) ? CARD_ACE : deal_q + 1'b1;
    dealt_sum = {1'b0, dealt_q} + {1'b0, n_new};
    dealt_d = (dealt_sum > 4'd6) ? 3'd6 : dealt_sum[2:0];
    err_d = err_q | hit_full | (n_ld > 3'd1);
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      deal_q  <= CARD_ACE;
      dealt_q <= '0;
      err_q   <= 1'b0;
    end else begin
      deal_q  <= deal_d;
      dealt_q <= dealt_d;
      err_q   <= err_d;
    end
  end

  // Mod 10 of a sum up to 27 via one conditional subtract.
  function automatic logic [SCORE_W-1:0] hand_score(
    input logic [CARD_W-1:0] a,
    input logic [CARD_W-1:0] b,
    input logic [CARD_W-1:0] c
  );
    logic [4:0] sum;
    sum = {1'b0, card_value(a)} + {1'b0, card_value(b)}
        + {1'b0, card_value(c)};
    if (sum >= 5'd20)
      sum = sum - 5'd20;
    else if (sum >= 5'd10)
      sum = sum - 5'd10;
    hand_score = sum[SCORE_W-1:0];
  endfunction

  assign pscore = hand_score(slot[0], slot[1], slot[2]);
  assign dscore = hand_score(slot[3], slot[4], slot[5]);

  assign pcard1      = slot[0];
  assign pcard2      = slot[1];
  assign pcard3      = slot[2];
  assign dcard1      = slot[3];
  assign dcard2      = slot[4];
  assign dcard3      = slot[5];
  assign deal_card   = deal_q;
  assign cards_dealt = dealt_q;
  assign load_error  = err_q;

endmodule

// File: tb/tb_baccarat_card_datapath.sv
// Randomized and directed bench for baccarat_card_datapath.
module tb_baccarat_card_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] ld;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore, deal_card;
  logic [2:0] cards_dealt;
  logic       load_error;
  logic [3:0] got [6];

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int m_slot [6];
  int m_k;
  int m_dealt;
  bit m_err;

  always #5 clk = ~clk;

  baccarat_card_datapath dut (
    .slow_clock  (clk),
    .reset       (reset),
    .load_pcard1 (ld[0]),
    .load_pcard2 (ld[1]),
    .load_pcard3 (ld[2]),
    .load_dcard1 (ld[3]),
    .load_dcard2 (ld[4]),
    .load_dcard3 (ld[5]),
    .pcard1      (pcard1),
    .pcard2      (pcard2),
    .pcard3      (pcard3),
    .dcard1      (dcard1),
    .dcard2      (dcard2),
    .dcard3      (dcard3),
    .pscore      (pscore),
    .dscore      (dscore),
    .deal_card   (deal_card),
    .cards_dealt (cards_dealt),
    .load_error  (load_error)
  );

  assign got[0] = pcard1;
  assign got[1] = pcard2;
  assign got[2] = pcard3;
  assign got[3] = dcard1;
  assign got[4] = dcard2;
  assign got[5] = dcard3;

  function automatic int val(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic int m_score(input int base);
    return (val(m_slot[base]) + val(m_slot[base+1])
          + val(m_slot[base+2])) % 10;
  endfunction

  function automatic int m_deal();
    return (m_k % 13) + 1;
  endfunction

  // One clock: apply inputs, advance the model, sample 1 time unit later.
  task automatic cyc(input logic [5:0] m, input logic r);
    int newly;
    int card;
    ld = m;
    reset = r;
    @(posedge clk);
    if (r) begin
      foreach (m_slot[i]) m_slot[i] = 0;
      m_k = 0;
      m_dealt = 0;
      m_err = 0;
    end else begin
      card = m_deal();
      newly = 0;
      if ($countones(m) > 1) m_err = 1;
      for (int i = 0; i < 6; i++) begin
        if (m[i]) begin
          if (m_slot[i] != 0) m_err = 1;
          else newly++;
          m_slot[i] = card;
        end
      end
      m_dealt = (m_dealt + newly > 6) ? 6 : m_dealt + newly;
      m_k++;
    end
    #1;
    ld = '0;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(6'b0, 1'b0);
  endtask

  task automatic test_reset();
    cyc(6'b111111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== 4'd0) begin
        failures++;
        $display("FAIL reset_slot%0d got=%0d exp=0", i, got[i]);
      end
    end
    checks++;
    if (pscore !== 4'd0 || dscore !== 4'd0) begin
      failures++;
      $display("FAIL reset_score got=%0d/%0d exp=0/0", pscore, dscore);
    end
    checks++;
    if (deal_card !== 4'd1) begin
      failures++;
      $display("FAIL reset_deal got=%0d exp=1", deal_card);
    end
    checks++;
    if (cards_dealt !== 3'd0 || load_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%0d/%0b exp=0/0",
               cards_dealt, load_error);
    end
  endtask

  task automatic test_basic_order();
    cyc(6'b0, 1'b1);
    cyc(6'b000001, 1'b0);
    cyc(6'b001000, 1'b0);
    cyc(6'b000010, 1'b0);
    cyc(6'b010000, 1'b0);
    checks++;
    if (pcard1 !== 4'd1 || dcard1 !== 4'd2 ||
        pcard2 !== 4'd3 || dcard2 !== 4'd4) begin
      failures++;
      $display("FAIL basic_cards got=%0d,%0d,%0d,%0d exp=1,2,3,4",
               pcard1, dcard1, pcard2, dcard2);
    end
    checks++;
    if (pscore !== 4'd4 || dscore !== 4'd6) begin
      failures++;
      $display("FAIL basic_score got=%0d/%0d exp=4/6", pscore, dscore);
    end
    checks++;
    if (cards_dealt !== 3'd4 || load_error !== 1'b0) begin
      failures++;
      $display("FAIL basic_flags got=%0d/%0b exp=4/0",
               cards_dealt, load_error);
    end
  endtask

  task automatic test_face_mod10();
    cyc(6'b0, 1'b1);
    idle(8);
    cyc(6'b000001, 1'b0);
    cyc(6'b000010, 1'b0);
    idle(2);
    cyc(6'b000100, 1'b0);
    checks++;
    if (pcard1 !== 4'd9 || pcard2 !== 4'd10 || pcard3 !== 4'd13) begin
      failures++;
      $display("FAIL face_cards got=%0d,%0d,%0d exp=9,10,13",
               pcard1, pcard2, pcard3);
    end
    checks++;
    if (pscore !== 4'd9) begin
      failures++;
      $display("FAIL face_score got=%0d exp=9", pscore);
    end
    cyc(6'b0, 1'b1);
    idle(7);
    cyc(6'b000100, 1'b0);
    cyc(6'b000001, 1'b0);
    cyc(6'b000010, 1'b0);
    checks++;
    if (pscore !== 4'd7 || pcard3 !== 4'd8) begin
      failures++;
      $display("FAIL mod10_score got=%0d card3=%0d exp=7 card3=8",
               pscore, pcard3);
    end
  endtask

  task automatic test_wrap();
    cyc(6'b0, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      cyc(6'b0, 1'b0);
      checks++;
      if (deal_card !== 4'((k % 13) + 1)) begin
        failures++;
        $display("FAIL wrap_deal k=%0d got=%0d exp=%0d",
                 k, deal_card, (k % 13) + 1);
      end
    end
    checks++;
    if ({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3} !== 24'd0) begin
      failures++;
      $display("FAIL wrap_slots got=%h exp=0",
               {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3});
    end
  endtask

  task automatic test_simultaneous();
    cyc(6'b0, 1'b1);
    idle(2);
    cyc(6'b001001, 1'b0);
    checks++;
    if (pcard1 !== 4'd3 || dcard1 !== 4'd3) begin
      failures++;
      $display("FAIL simul_cards got=%0d/%0d exp=3/3", pcard1, dcard1);
    end
    checks++;
    if (cards_dealt !== 3'd2 || load_error !== 1'b1) begin
      failures++;
      $display("FAIL simul_flags got=%0d/%0b exp=2/1",
               cards_dealt, load_error);
    end
    idle(5);
    checks++;
    if (load_error !== 1'b1) begin
      failures++;
      $display("FAIL simul_sticky got=%0b exp=1", load_error);
    end
  endtask

  task automatic test_overwrite();
    cyc(6'b0, 1'b1);
    cyc(6'b000001, 1'b0);
    idle(4);
    cyc(6'b000001, 1'b0);
    checks++;
    if (pcard1 !== 4'd6 || cards_dealt !== 3'd1 || load_error !== 1'b1) begin
      failures++;
      $display("FAIL overwrite got=%0d/%0d/%0b exp=6/1/1",
               pcard1, cards_dealt, load_error);
    end
  endtask

  task automatic test_reset_mid();
    cyc(6'b0, 1'b1);
    cyc(6'b000001, 1'b0);
    cyc(6'b000010, 1'b0);
    cyc(6'b001000, 1'b0);
    cyc(6'b100100, 1'b1);
    checks++;
    if ({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3} !== 24'd0 ||
        pscore !== 4'd0 || dscore !== 4'd0) begin
      failures++;
      $display("FAIL midreset_slots got=%h %0d/%0d exp=0",
               {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3},
               pscore, dscore);
    end
    checks++;
    if (deal_card !== 4'd1 || cards_dealt !== 3'd0 ||
        load_error !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state got=%0d/%0d/%0b exp=1/0/0",
               deal_card, cards_dealt, load_error);
    end
  endtask

  task automatic test_random();
    logic [5:0] m;
    logic       r;
    int         sel;
    cyc(6'b0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 19);
      if (sel < 8) m = 6'b0;
      else if (sel < 17) m = 6'(1 << $urandom_range(0, 5));
      else m = 6'($urandom_range(0, 63));
      r = ($urandom_range(0, 29) == 0);
      cyc(m, r);
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got[i] !== 4'(m_slot[i])) begin
          failures++;
          $display("FAIL rand_slot%0d n=%0d got=%0d exp=%0d",
                   i, n, got[i], m_slot[i]);
        end
      end
      checks++;
      if (pscore !== 4'(m_score(0)) || dscore !== 4'(m_score(3))) begin
        failures++;
        $display("FAIL rand_score n=%0d got=%0d/%0d exp=%0d/%0d",
                 n, pscore, dscore, m_score(0), m_score(3));
      end
      checks++;
      if (deal_card !== 4'(m_deal())) begin
        failures++;
        $display("FAIL rand_deal n=%0d got=%0d exp=%0d",
                 n, deal_card, m_deal());
      end
      checks++;
      if (cards_dealt !== 3'(m_dealt) || load_error !== m_err) begin
        failures++;
        $display("FAIL rand_flags n=%0d got=%0d/%0b exp=%0d/%0b",
                 n, cards_dealt, load_error, m_dealt, m_err);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ld = '0;
    @(negedge clk);
    test_reset();
    test_basic_order();
    test_face_mod10();
    test_wrap();
    test_simultaneous();
    test_overwrite();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
